ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver for N digits.
- Replaces the single-anode, hard-coded SSD scan and hex decode in the top level.
- Adds the following features:
  - per-digit enable
  - per-digit blinking
  - decimal points
  - leading-zero suppression
  - tear-free frame latching
- Sits between game or debug registers and the board An/Ca..Cg/Dp pins.

Parameters:
- N_DIGITS, 8: number of digits and anodes driven (1..8).
- SCAN_DIV_W, 18: width of the per-digit dwell counter. The digit advances every 2^SCAN_DIV_W Clk cycles.
- BLINK_DIV_W, 26: width of the blink counter. The blink phase toggles every 2^BLINK_DIV_W Clk cycles.

Ports:
- Clk  in  1  system clock (100 MHz)
- Reset  in  1  synchronous, active-high reset
- digits_in  in  4*N_DIGITS  hex value per digit; digit k = bits [4k+3:4k]; digit 0 is rightmost
- dp_in  in  N_DIGITS  1 = decimal point lit for digit k
- enable_mask  in  N_DIGITS  1 = digit k displayed; 0 = anode k forced off
- blink_mask  in  N_DIGITS  1 = digit k blanked while blink_phase = 1
- lz_suppress  in  1  1 = leading-zero suppression on
- An  out  N_DIGITS  anodes, active-low, at most one low
- Cathodes  out  7  {Ca,Cb,Cc,Cd,Ce,Cf,Cg}, active-low
- Dp  out  1  decimal-point cathode, active-low
- digit_idx  out  clog2(N_DIGITS) (min 1)  index of the digit currently driven
- frame_start  out  1  one-cycle pulse when the shadow registers are reloaded

Behaviour:
- Reset is synchronous. When Reset = 1 at a Clk edge:
  - all counters are zeroed, digit_idx = 0, blink_phase = 0
  - the shadow registers are cleared
  - An = all 1, Cathodes = 7'h7F, Dp = 1, frame_start = 0
- Reset asserted mid-frame has the same effect. The display is dark on the next cycle.
- Dwell counter:
  - free-running SCAN_DIV_W bits, increments every Clk.
  - tick = counter all-ones. On tick, digit_idx <= (digit_idx == N_DIGITS-1) ? 0 : digit_idx+1.
  - The wrap is explicit, so a non-power-of-2 N_DIGITS never reaches an illegal index.
- Frame latch:
  - on tick with digit_idx == N_DIGITS-1, digits_in, dp_in, enable_mask, blink_mask and lz_suppress are copied into shadow registers.
  - frame_start pulses the same cycle.
  - All display decisions use shadow values only. Input changes mid-frame never tear.
  - The first frame after reset shows blank (shadow = 0 with enable = 0).
- Blink counter:
  - free-running BLINK_DIV_W bits; on all-ones, blink_phase toggles.
  - Blink is not frame-synchronised.
- Leading-zero suppression (from shadow values):
  - lz_blank[k] = 1 when shadow lz_suppress = 1, k != 0, and every digit j >= k (j < N_DIGITS) has value 0.
  - Digit 0 is never suppressed.
  - Suppressed digits keep their dp. Segments are off, the anode stays on if dp is lit, otherwise the anode is off.
- Full blank:
  - blank[k] = ~enable[k] | (blink[k] & blink_phase).
  - A blanked digit drives all anodes high, Cathodes = 7'h7F, Dp = 1.
- Outputs are registered. They reflect digit_idx of the previous cycle, so the latency is 1 Clk after an index change.
  - An = ~(1 << idx) unless the digit is blanked or fully suppressed without dp.
  - Cathodes = hex decode of the digit nibble. The table is identical to the existing SSD map:
    - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
    - 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000
  - Dp = ~dp[idx].
- N_DIGITS = 1: digit_idx stays 0 and a frame latch occurs every tick.

Decomposition:
- Package ssd_pkg holds:
  - hex_to_seg function (16-entry table above)
  - SEG_OFF = 7'h7F
  - the clog2 helper used for the digit_idx width
- One sub-module, ssd_hex_decode: combinational, 4-bit in, 7-bit active-low out, wrapping hex_to_seg.
- The scan, latch, blink and suppression logic stay in ssd_scan_driver.

Test Plan (bench uses N_DIGITS=4, SCAN_DIV_W=2, BLINK_DIV_W=5):
- Reset, then digits_in=16'h12AF, enable=4'hF, others 0. After the first frame_start:
  - An cycles 1110,1101,1011,0111, dwell 4 Clk each.
  - Cathodes cycle F=0111000, A=0001000, 2=0010010, 1=1001111.
- Change digits_in to 16'h3333 mid-frame: the rest of the current frame still shows 12AF, and 3333 appears only after the next frame_start.
- digits_in=16'h0070, lz_suppress=1, dp_in=4'b1000:
  - digit 3 anode low with Cathodes=7F and Dp=0
  - digit 2 fully dark
  - digits 1,0 show 7,0.
- blink_mask=4'b0001: digit 0 alternates between shown and dark every 32 Clk. Other digits are unaffected.
- enable_mask=4'b0101: whenever digit_idx is 1 or 3, An=1111.
- Assert Reset mid-frame for 1 cycle: the next cycle An=1111, Cathodes=7F, Dp=1, digit_idx=0, and scanning restarts from digit 0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SEG_OFF    : active-low cathode pattern with every segment dark
//   idx_width  : bits needed to index n digits (never less than 1)
//   hex_to_seg : nibble -> {Ca,Cb,Cc,Cd,Ce,Cf,Cg}, active-low
package ssd_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex-to-segment decoder.
//   nibble : 4-bit hex value
//   seg    : {Ca..Cg}, active-low
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-digit enable,
// blink, decimal points, leading-zero suppression and frame latching.
//   Clk, Reset   : clock, synchronous active-high reset
//   digits_in    : 4 bits per digit, digit 0 rightmost
//   dp_in        : decimal point per digit
//   enable_mask  : digit shown when 1
//   blink_mask   : digit blanked while the blink phase is high
//   lz_suppress  : leading-zero suppression enable
//   An           : anodes, active-low, at most one low
//   Cathodes     : {Ca..Cg}, active-low
//   Dp           : decimal-point cathode, active-low
//   digit_idx    : digit currently selected by the scanner
//   frame_start  : one-cycle pulse when the shadow registers reload
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int SCAN_DIV_W  = 18,
  parameter int BLINK_DIV_W = 26,
  localparam int IDX_W      = idx_width(N_DIGITS)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   enable_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_suppress,
  output logic [N_DIGITS-1:0]   An,
  output logic [6:0]            Cathodes,
  output logic                  Dp,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_start
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [SCAN_DIV_W-1:0]  scan_cnt;
  logic [BLINK_DIV_W-1:0] blink_cnt;
  logic                   blink_phase;
  logic                   scan_tick;
  logic                   frame_tick;

  logic [4*N_DIGITS-1:0]  sh_digits;
  logic [N_DIGITS-1:0]    sh_dp;
  logic [N_DIGITS-1:0]    sh_en;
  logic [N_DIGITS-1:0]    sh_blink;
  logic                   sh_lz;

  logic [N_DIGITS-1:0]    lz_blank;
  logic [N_DIGITS-1:0]    blank;
  logic                   all_zero;
  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic                   cur_blank;
  logic                   cur_lz;
  logic [6:0]             cur_seg;
  logic [N_DIGITS-1:0]    sel_an;

  logic [N_DIGITS-1:0]    an_p0;
  logic [6:0]             seg_p0;
  logic                   dp_p0;

  assign scan_tick  = &scan_cnt;
  // Inputs are sampled only as the last digit finishes, so a frame never
  // mixes old and new values.
  assign frame_tick = scan_tick && (digit_idx == LAST_IDX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      digit_idx   <= '0;
      frame_start <= 1'b0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_en       <= '0;
      sh_blink    <= '0;
      sh_lz       <= 1'b0;
    end else begin
      scan_cnt    <= scan_cnt + SCAN_DIV_W'(1);
      blink_cnt   <= blink_cnt + BLINK_DIV_W'(1);
      frame_start <= frame_tick;
      if (&blink_cnt)
        blink_phase <= ~blink_phase;
      // Explicit wrap keeps non-power-of-two digit counts in range.
      if (scan_tick)
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
      if (frame_tick) begin
        sh_digits <= digits_in;
        sh_dp     <= dp_in;
        sh_en     <= enable_mask;
        sh_blink  <= blink_mask;
        sh_lz     <= lz_suppress;
      end
    end
  end

  // A digit is a leading zero when it and every digit to its left are zero;
  // digit 0 always shows so a zero value still reads "0".
  always_comb begin
    all_zero = 1'b1;
    lz_blank = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      all_zero    = all_zero && (sh_digits[4*k +: 4] == 4'h0);
      lz_blank[k] = sh_lz && (k != 0) && all_zero;
    end
  end

  assign blank  = ~sh_en | (sh_blink & {N_DIGITS{blink_phase}});
  assign sel_an = ~(N_DIGITS'(1) << digit_idx);

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_lz    = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nib   = sh_digits[4*k +: 4];
        cur_dp    = sh_dp[k];
        cur_blank = blank[k];
        cur_lz    = lz_blank[k];
      end
    end
  end

  ssd_hex_decode u_hex_decode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // A suppressed zero keeps its anode only to light its decimal point.
  always_comb begin
    an_p0  = '1;
    seg_p0 = SEG_OFF;
    dp_p0  = 1'b1;
    if (!cur_blank) begin
      dp_p0 = ~cur_dp;
      if (cur_lz) begin
        if (cur_dp)
          an_p0 = sel_an;
      end else begin
        an_p0  = sel_an;
        seg_p0 = cur_seg;
      end
    end
  end

  // ---- stage p0 -> pin registers ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      An       <= '1;
      Cathodes <= SEG_OFF;
      Dp       <= 1'b1;
    end else begin
      An       <= an_p0;
      Cathodes <= seg_p0;
      Dp       <= dp_p0;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver (4 digits, 4-cycle dwell, 32-cycle
// blink). Stimulus pushes the expected pin state per displayed digit; a
// monitor pops one entry each time the pins move on to a new digit.
module tb_ssd_scan_driver;

  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S3  = 7'b0000110;
  localparam logic [6:0] S7  = 7'b0001111;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SF  = 7'b0111000;
  localparam logic [6:0] OFF = 7'h7F;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  enable_mask;
  logic [3:0]  blink_mask;
  logic        lz_suppress;
  logic [3:0]  An;
  logic [6:0]  Cathodes;
  logic        Dp;
  logic [1:0]  digit_idx;
  logic        frame_start;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  ssd_scan_driver #(
    .N_DIGITS    (4),
    .SCAN_DIV_W  (2),
    .BLINK_DIV_W (5)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .enable_mask (enable_mask),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .An          (An),
    .Cathodes    (Cathodes),
    .Dp          (Dp),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 Clk = ~Clk;

  // Cycles since reset release, owned by the bench.
  always @(posedge Clk) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    exp_t e;
    e.idx = idx;
    e.an  = an;
    e.seg = seg;
    e.dp  = dp;
    q.push_back(e);
  endtask

  task automatic push_dark(input logic [1:0] idx);
    push(idx, 4'b1111, OFF, 1'b1);
  endtask

  task automatic push_12af();
    push(2'd0, 4'b1110, SF, 1'b1);
    push(2'd1, 4'b1101, SA, 1'b1);
    push(2'd2, 4'b1011, S2, 1'b1);
    push(2'd3, 4'b0111, S1, 1'b1);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (!frame_start && n < 40);
    if (!frame_start) begin
      total++;
      bad++;
      $display("FAIL frame_start_timeout got=none want=pulse within %0d cycles", n);
    end else begin
      check("frame_start_phase", cyc % 16, 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 80) begin
      @(posedge Clk); #1;
      n++;
    end
    check("queue_drain", q.size(), 0);
  endtask

  // Monitor: pins shown at a sample reflect the index of the previous
  // sample, so a new digit appears one sample after digit_idx moves.
  initial begin
    logic [1:0] d1;
    logic [1:0] d2;
    exp_t       e;
    d1 = '0;
    d2 = '0;
    forever begin
      @(posedge Clk); #1;
      if (Reset) begin
        d1 = '0;
        d2 = '0;
      end else begin
        if (d1 != d2 && q.size() > 0) begin
          e = q.pop_front();
          check($sformatf("d%0d.idx", e.idx), d1, e.idx);
          check($sformatf("d%0d.An", e.idx), An, e.an);
          check($sformatf("d%0d.Cathodes", e.idx), Cathodes, e.seg);
          check($sformatf("d%0d.Dp", e.idx), Dp, e.dp);
        end
        d2 = d1;
        d1 = digit_idx;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph;
    digits_in   = 16'h12AF;
    dp_in       = 4'b0000;
    enable_mask = 4'hF;
    blink_mask  = 4'b0000;
    lz_suppress = 1'b0;
    Reset       = 1'b1;

    repeat (3) @(posedge Clk);
    #1;
    check("rst.An", An, 4'b1111);
    check("rst.Cathodes", Cathodes, OFF);
    check("rst.Dp", Dp, 1'b1);
    check("rst.digit_idx", digit_idx, 2'd0);
    check("rst.frame_start", frame_start, 1'b0);

    // First frame after reset shows the cleared shadow: dark.
    push_dark(2'd1);
    push_dark(2'd2);
    push_dark(2'd3);
    @(negedge Clk);
    Reset = 1'b0;

    wait_fs();
    push_12af();

    // Mid-frame change must not tear the frame in progress.
    repeat (6) @(negedge Clk);
    digits_in = 16'h3333;
    wait_fs();
    push(2'd0, 4'b1110, S3, 1'b1);
    push(2'd1, 4'b1101, S3, 1'b1);
    push(2'd2, 4'b1011, S3, 1'b1);
    push(2'd3, 4'b0111, S3, 1'b1);
    drain();

    // Leading-zero suppression with a dp on a suppressed digit.
    @(negedge Clk);
    digits_in   = 16'h0070;
    lz_suppress = 1'b1;
    dp_in       = 4'b1000;
    wait_fs();
    push(2'd0, 4'b1110, S0, 1'b1);
    push(2'd1, 4'b1101, S7, 1'b1);
    push_dark(2'd2);
    push(2'd3, 4'b0111, OFF, 1'b0);
    drain();

    // Blink on digit 0: phase follows cycles since reset / 32.
    @(negedge Clk);
    digits_in   = 16'h12AF;
    lz_suppress = 1'b0;
    dp_in       = 4'b0000;
    blink_mask  = 4'b0001;
    for (int f = 0; f < 4; f++) begin
      wait_fs();
      ph = (cyc / 32) % 2;
      if (ph == 1) push_dark(2'd0);
      else         push(2'd0, 4'b1110, SF, 1'b1);
      push(2'd1, 4'b1101, SA, 1'b1);
      push(2'd2, 4'b1011, S2, 1'b1);
      push(2'd3, 4'b0111, S1, 1'b1);
    end
    drain();

    // Disabled digits go fully dark; dp on a lit digit.
    @(negedge Clk);
    blink_mask  = 4'b0000;
    enable_mask = 4'b0101;
    dp_in       = 4'b0001;
    wait_fs();
    push(2'd0, 4'b1110, SF, 1'b0);
    push_dark(2'd1);
    push(2'd2, 4'b1011, S2, 1'b1);
    push_dark(2'd3);
    drain();

    // One-cycle reset in the middle of a frame.
    @(negedge Clk);
    enable_mask = 4'hF;
    dp_in       = 4'b0000;
    wait_fs();
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("midrst.An", An, 4'b1111);
    check("midrst.Cathodes", Cathodes, OFF);
    check("midrst.Dp", Dp, 1'b1);
    check("midrst.digit_idx", digit_idx, 2'd0);
    check("midrst.frame_start", frame_start, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    push_dark(2'd1);
    push_dark(2'd2);
    push_dark(2'd3);
    for (int i = 1; i <= 4; i++) begin
      @(posedge Clk); #1;
      check($sformatf("restart.idx@%0d", i), digit_idx, (i < 4) ? 2'd0 : 2'd1);
    end
    wait_fs();
    push_12af();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
